// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message sequencer.
// The IV is kept here so reference code and the design agree on one copy.
package sha256_pkg;

    localparam int          BLOCK_WORDS = 16;
    localparam logic [31:0] PAD_WORD    = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        FEED,
        WAIT,
        DONE
    } seq_state_t;

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

endpackage

// File: rtl/sha256_pad_word.sv
// Produces one padded message word from its global word index and the message length.
// Also reports whether that word takes a word from the host.
module sha256_pad_word
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic [LEN_W-1:0] g,
    input  logic [LEN_W-1:0] f,
    input  logic [1:0]       r,
    input  logic             last,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      host,
    output logic [31:0]      word,
    output logic             consume
);

    logic [63:0] bit_len;

    assign bit_len = 64'(len) << 3;

    // NOTE: every output gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        word    = '0;
        consume = 1'b0;
        if (g < f) begin
            word    = host;
            consume = 1'b1;
        end else if (g == f) begin
            consume = (r != 2'd0);
            case (r)
                2'd0:    word = PAD_WORD;
                2'd1:    word = {host[31:24], 8'h80, 16'h0000};
                2'd2:    word = {host[31:16], 8'h80, 8'h00};
                default: word = {host[31:8], 8'h80};
            endcase
        end else if (last && g[3:0] == 4'd14) begin
            word = bit_len[63:32];
        end else if (last && g[3:0] == 4'd15) begin
            word = bit_len[31:0];
        end
    end

endmodule

// File: rtl/sha256_msg_sequencer.sv
// Pads a host message into 16-word blocks and feeds them to the SHA-256 core.
// The core's hash is latched as the digest once the final block completes.
module sha256_msg_sequencer
    import sha256_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             msg_start,
    input  logic [LEN_W-1:0] msg_len_bytes,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             core_start,
    output logic             core_new_msg_n,
    input  logic             core_word_req,
    output logic [31:0]      core_word,
    output logic             core_word_valid,
    input  logic             core_done,
    input  logic [255:0]     core_hash,
    output logic [255:0]     digest,
    output logic             digest_valid,
    output logic             busy
);

    seq_state_t state, state_next;

    logic [31:0]      blk_buf [BLOCK_WORDS];
    logic [3:0]       k;
    logic [LEN_W-1:0] b, g, len, n_blocks;
    logic [LEN_W-1:0] f, n_start;
    logic [LEN_W:0]   len_pad;
    logic [1:0]       r;
    logic             last_block, start_ok, fill_step, feed_step;
    logic [31:0]      pad_word;
    logic             pad_consume;

    assign f          = {2'b00, len[LEN_W-1:2]};
    assign r          = len[1:0];
    assign last_block = (b == n_blocks - LEN_W'(1));
    assign len_pad    = {1'b0, msg_len_bytes} + (LEN_W+1)'(8);
    assign n_start    = LEN_W'(len_pad >> 6) + LEN_W'(1);
    assign start_ok   = msg_start && (state == IDLE || state == DONE);
    assign fill_step  = (state == FILL) && (!pad_consume || in_valid);
    assign feed_step  = (state == FEED) && core_word_req;

    sha256_pad_word #(.LEN_W(LEN_W)) u_pad (
        .g       (g),
        .f       (f),
        .r       (r),
        .last    (last_block),
        .len     (len),
        .host    (in_data),
        .word    (pad_word),
        .consume (pad_consume)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next      = state;
        in_ready        = 1'b0;
        core_start      = 1'b0;
        core_new_msg_n  = 1'b1;
        core_word       = '0;
        core_word_valid = 1'b0;
        busy            = 1'b1;
        case (state)
            IDLE, DONE: begin
                busy = 1'b0;
                if (msg_start) state_next = FILL;
            end
            FILL: begin
                in_ready = pad_consume;
                if (fill_step && k == 4'd15) state_next = ISSUE;
            end
            ISSUE: begin
                core_start     = 1'b1;
                core_new_msg_n = (b != '0);
                state_next     = FEED;
            end
            FEED: begin
                core_word       = blk_buf[k];
                core_word_valid = core_word_req;
                if (feed_step && k == 4'd15) state_next = WAIT;
            end
            WAIT: begin
                if (core_done) state_next = last_block ? DONE : FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len          <= '0;
            n_blocks     <= '0;
            b            <= '0;
            g            <= '0;
            k            <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else begin
            if (start_ok) begin
                len          <= msg_len_bytes;
                n_blocks     <= n_start;
                b            <= '0;
                g            <= '0;
                k            <= '0;
                digest_valid <= 1'b0;
            end
            if (fill_step) begin
                k <= k + 4'd1;
                g <= g + LEN_W'(1);
            end
            // k wraps to 0 after word 15, ready for the next phase.
            if (feed_step) k <= k + 4'd1;
            if (state == WAIT && core_done) begin
                if (last_block) begin
                    digest       <= core_hash;
                    digest_valid <= 1'b1;
                end else begin
                    b <= b + LEN_W'(1);
                end
            end
        end
    end

    // NOTE: the block buffer has no reset; every word is written in FILL before FEED reads it.
    always_ff @(posedge clk) begin
        if (fill_step) blk_buf[k] <= pad_word;
    end

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Randomized scoreboard bench: byte-level padding and SHA-256 reference predict
// every fed word, chaining flag and digest; a bench-side core model hashes what it is fed.
module tb_sha256_msg_sequencer;
    import sha256_pkg::*;

    localparam int LEN_W = 32;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic             clk, reset_n;
    logic             msg_start;
    logic [LEN_W-1:0] msg_len_bytes;
    logic [31:0]      in_data;
    logic             in_valid, in_ready;
    logic             core_start, core_new_msg_n, core_word_req;
    logic [31:0]      core_word;
    logic             core_word_valid, core_done;
    logic [255:0]     core_hash, digest;
    logic             digest_valid, busy;

    sha256_msg_sequencer #(.LEN_W(LEN_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .msg_start       (msg_start),
        .msg_len_bytes   (msg_len_bytes),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .core_start      (core_start),
        .core_new_msg_n  (core_new_msg_n),
        .core_word_req   (core_word_req),
        .core_word       (core_word),
        .core_word_valid (core_word_valid),
        .core_done       (core_done),
        .core_hash       (core_hash),
        .digest          (digest),
        .digest_valid    (digest_valid),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int blocks_seen  = 0;

    logic [7:0]   msg_q[$];
    logic [31:0]  exp_words[$];
    logic         exp_nm[$];
    logic [255:0] exp_dig[$];

    bit req_toggle  = 1'b0;
    bit spurious_en = 1'b0;

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic note_fail(input string name, input string detail);
        n_compared++;
        n_mismatched++;
        $display("FAIL %s: %s", name, detail);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2, s0, s1;
        logic [255:0] hout;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            s1 = rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25);
            t1 = v[7] + s1 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            s0 = rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22);
            t2 = s0 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) hout[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return hout;
    endfunction

    // Byte-level FIPS 180-4 padding of msg_q; pushes expected words, chaining flags and digest.
    task automatic build_expected();
        logic [7:0]   p[$];
        logic [63:0]  bit_len;
        logic [511:0] blk;
        logic [255:0] h;
        p = msg_q;
        bit_len = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bit_len[8*i +: 8]);
        h = SHA256_IV;
        for (int bi = 0; bi < p.size() / 64; bi++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*bi + j];
            for (int j = 0; j < 16; j++) exp_words.push_back(blk[511-32*j -: 32]);
            exp_nm.push_back(bi != 0);
            h = compress(h, blk);
        end
        exp_dig.push_back(h);
    endtask

    // Host word idx: message bytes left-justified, bytes past the end filled with junk.
    function automatic logic [31:0] host_word(input int idx);
        logic [31:0] w;
        int          p;
        for (int j = 0; j < 4; j++) begin
            p = 4 * idx + j;
            w[31-8*j -: 8] = (p < msg_q.size()) ? msg_q[p] : 8'($urandom);
        end
        return w;
    endfunction

    // Core model: observe at negedge, drive just after posedge.
    initial begin
        logic [511:0] cm_blk;
        logic [255:0] cm_h;
        int           cm_cnt, cm_delay;
        bit           cm_in_block, cm_pending;
        core_word_req = 1'b0;
        core_done     = 1'b0;
        core_hash     = '0;
        cm_blk = '0; cm_h = '0; cm_cnt = 0; cm_delay = 0;
        cm_in_block = 1'b0; cm_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cm_in_block = 1'b0;
                cm_pending  = 1'b0;
            end else begin
                if (core_start) begin
                    cm_in_block = 1'b1;
                    cm_cnt      = 0;
                    if (!core_new_msg_n) cm_h = SHA256_IV;
                end
                if (cm_in_block && core_word_valid) begin
                    cm_blk[511-32*cm_cnt -: 32] = core_word;
                    cm_cnt++;
                    if (cm_cnt == 16) begin
                        cm_in_block = 1'b0;
                        cm_pending  = 1'b1;
                        cm_delay    = int'($urandom_range(0, 3));
                        cm_h        = compress(cm_h, cm_blk);
                    end
                end
            end
            @(posedge clk);
            #1;
            core_done = 1'b0;
            if (!reset_n) begin
                core_word_req = 1'b0;
            end else if (cm_pending) begin
                core_word_req = 1'b0;
                if (cm_delay == 0) begin
                    core_done  = 1'b1;
                    core_hash  = cm_h;
                    cm_pending = 1'b0;
                end else begin
                    cm_delay--;
                end
            end else if (cm_in_block) begin
                core_word_req = req_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            end else begin
                core_word_req = 1'b0;
                if (spurious_en && $urandom_range(0, 3) == 0) begin
                    core_done = 1'b1;
                    core_hash = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        logic prev_dv;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                blocks_seen++;
                if (exp_nm.size() == 0) note_fail("new_msg_n", "unexpected core_start");
                else check("new_msg_n", 256'(core_new_msg_n), 256'(exp_nm.pop_front()));
            end
            if (core_word_valid) begin
                if (exp_words.size() == 0) note_fail("core_word", "unexpected word");
                else check("core_word", 256'(core_word), 256'(exp_words.pop_front()));
            end
            if (digest_valid && !prev_dv) begin
                if (exp_dig.size() == 0) note_fail("digest", "unexpected digest_valid");
                else check("digest", digest, exp_dig.pop_front());
            end
            prev_dv = digest_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        exp_words.delete();
        exp_nm.delete();
        exp_dig.delete();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg();
        build_expected();
        @(posedge clk);
        #1;
        msg_len_bytes = LEN_W'(msg_q.size());
        msg_start     = 1'b1;
        @(posedge clk);
        #1;
        msg_start = 1'b0;
    endtask

    // Entered just after a posedge; returns at a negedge.
    task automatic drive_msg(input bit toggle, input bit spurious, input bit abort_in_feed,
                             output bit reached, output int accepted, output int extra_ready);
        int nw;
        nw = (msg_q.size() + 3) / 4;
        accepted = 0; extra_ready = 0; reached = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (accepted < nw) begin
                in_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
                in_data  = host_word(accepted);
            end else begin
                in_valid = 1'b0;
                in_data  = $urandom;
            end
            msg_start = 1'b0;
            if (spurious && busy && $urandom_range(0, 4) == 0) begin
                msg_start     = 1'b1;
                msg_len_bytes = $urandom;
            end
            @(negedge clk);
            if (in_ready && accepted >= nw) extra_ready++;
            if (in_valid && in_ready) accepted++;
            if (digest_valid || (abort_in_feed && core_word_valid)) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        msg_start = 1'b0;
    endtask

    task automatic run_full(input string name, input bit toggle, input bit spurious);
        bit reached;
        int accepted, extra, b0, len;
        len = msg_q.size();
        req_toggle  = toggle;
        spurious_en = spurious;
        b0 = blocks_seen;
        start_msg();
        drive_msg(toggle, spurious, 1'b0, reached, accepted, extra);
        spurious_en = 1'b0;
        if (!reached) begin
            note_fail({name, "_timeout"}, $sformatf("no digest_valid, L=%0d", len));
            do_reset();
        end else begin
            check({name, "_handshakes"}, 256'(accepted), 256'((len + 3) / 4));
            check({name, "_extra_ready"}, 256'(extra), 256'(0));
            check({name, "_blocks"}, 256'(blocks_seen - b0), 256'((len + 8) / 64 + 1));
            @(posedge clk);
            #1;
            check({name, "_sb_left"}, 256'(exp_words.size() + exp_nm.size() + exp_dig.size()), 256'(0));
        end
    endtask

    task automatic set_abc();
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    endtask

    task automatic set_random(input int len);
        msg_q.delete();
        repeat (len) msg_q.push_back(8'($urandom));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string s56;
        bit    reached;
        int    accepted, extra;
        int    lens [5] = '{55, 56, 64, 119, 120};
        reset_n = 1'b0; msg_start = 1'b0; msg_len_bytes = '0;
        in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 256'({in_ready, core_start, core_new_msg_n, core_word, core_word_valid, digest_valid, busy}),
              256'({1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0}));
        check("reset_digest", digest, 256'h0);
        @(negedge clk);
        reset_n = 1'b1;

        set_abc();
        run_full("abc", 1'b0, 1'b0);
        check("abc_kat", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        msg_q.delete();
        run_full("empty", 1'b0, 1'b0);
        check("empty_kat", digest, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        msg_q.delete();
        for (int i = 0; i < s56.len(); i++) msg_q.push_back(s56[i]);
        run_full("l56", 1'b1, 1'b0);
        check("l56_kat", digest, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);

        set_random(64);
        run_full("l64_toggle", 1'b1, 1'b0);

        // Reset while block 0 is being fed to the core.
        set_random(64);
        req_toggle = 1'b0;
        start_msg();
        drive_msg(1'b0, 1'b0, 1'b1, reached, accepted, extra);
        if (!reached) note_fail("abort_feed", "FEED never reached");
        reset_n = 1'b0;
        #1;
        check("abort_ctrl", 256'({in_ready, core_start, core_new_msg_n, core_word, core_word_valid, digest_valid, busy}),
              256'({1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0}));
        check("abort_digest", digest, 256'h0);
        repeat (2) @(negedge clk);
        exp_words.delete();
        exp_nm.delete();
        exp_dig.delete();
        reset_n = 1'b1;
        set_abc();
        run_full("abc_after_reset", 1'b0, 1'b0);
        check("abc_after_reset_kat", digest, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        set_random(100);
        run_full("spurious", 1'b1, 1'b1);

        foreach (lens[i]) begin
            set_random(lens[i]);
            run_full($sformatf("bound_%0d", lens[i]), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) begin
            set_random(int'($urandom_range(0, 200)));
            run_full($sformatf("rand_%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sequencer.md
# sha256_msg_sequencer

Sequences an arbitrary-length message through the SHA-256 core's controller. It accepts 32-bit big-endian message words from the host, applies FIPS 180-4 padding and the 64-bit bit-length field, and buffers one 16-word block at a time. Each block is fed to the core's word-load interface, with first-block chaining-reset signalling, and the final 256-bit digest is latched after the last block. It sits between the NIOS II wrapper and the core controller.

## Interface

- LEN_W, 32: width of message byte-length input; max message 2^LEN_W-1 bytes
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low; clock clk
- msg_start  in  1  1-cycle pulse; latches msg_len_bytes, begins message
- msg_len_bytes  in  LEN_W  message length L in bytes
- in_data  in  32  host message word, big-endian; partial last word left-justified
- in_valid  in  1  host word valid
- in_ready  out  1  sequencer accepts in_data when in_valid&in_ready
- core_start  out  1  1-cycle pulse per block
- core_new_msg_n  out  1  active-low; low only in the core_start cycle of block 0 (core reloads IV)
- core_word_req  in  1  core requests block words
- core_word  out  32  block word to core
- core_word_valid  out  1  core_word valid
- core_done  in  1  core finished current block
- core_hash  in  256  core chaining/digest value
- digest  out  256  final hash
- digest_valid  out  1  digest valid; held until next accepted msg_start
- busy  out  1  high from accepted msg_start until digest_valid

## Operation

- States: IDLE, FILL, ISSUE, FEED, WAIT, DONE.
- IDLE/DONE + msg_start -> FILL; latch L; block count N = floor((L+8)/64)+1; clear digest_valid; block index b=0. msg_start while busy is ignored.
- FILL: build buffer words 0..15 of block b, one per cycle. Global word index g = 16b+k. Let F = floor(L/4), r = L mod 4.
  - g<F: host word (consumes one host handshake; stall on !in_valid).
  - g==F: r!=0 -> host word with bytes r..3 forced to 0, byte r = 0x80 (consumes host word); r==0 -> 0x8000_0000, no host consume.
  - g>F: 0, except in last block (b==N-1): word 14 = (L*8)>>32, word 15 = (L*8)[31:0] (64-bit zero-extended).
- in_ready = 1 only in FILL when g<F or (g==F and r!=0).
- FILL complete (k=15 written) -> ISSUE: core_start=1 one cycle, core_new_msg_n=0 iff b==0 -> FEED.
- FEED: core_word = buf[k], core_word_valid = core_word_req; k advances on core_word_req&core_word_valid; after word 15 -> WAIT.
- WAIT: on core_done: b<N-1 -> b++, FILL; else digest<=core_hash, digest_valid=1 -> DONE.
- core_done outside WAIT ignored. Host words beyond F (or F+1 if r!=0) are never accepted.

## Timing

- Reset values: in_ready 0, core_start 0, core_new_msg_n 1, core_word 0, core_word_valid 0, digest 0, digest_valid 0, busy 0; state IDLE.
- FILL: 16 cycles minimum per block, +1 per host stall cycle.
- ISSUE: exactly 1 cycle; FEED starts the next cycle; 16 words in 16 cycles with req held high.
- digest/digest_valid update the cycle after core_done in WAIT of block N-1.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values, partial digest discarded.
- Boundaries: L=0 -> N=1; L=55 -> N=1; L=56 -> N=2; L=64 -> N=2; L=119 -> N=2; L=120 -> N=3.

## Structure

- sha256_pkg: BLOCK_WORDS=16, PAD_WORD=32'h8000_0000, state encoding, SHA-256 IV constants for bench reference.
- One natural sub-module: sha256_pad_word (combinational: g, F, r, last-block flag, L, host word -> padded word + consume flag).
- 16x32 block buffer, word counter k, block counter b, global word counter g in the sequencer.

## Test plan

- L=3, host word 0x6162_6300 ("abc") -> 1 block, buffer word 0 = 0x6162_6380, word 15 = 0x18; digest = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- L=0, no host words -> in_ready never high; word 0 = 0x8000_0000, word 15 = 0; digest = e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- L=56 "abcdbcdecdefdefg…nopq" -> N=2, core_new_msg_n low only on block 0; digest = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
- L=64, in_valid toggling 50% -> 16 host handshakes only; block 1 word 0 = 0x8000_0000, word 15 = 0x200; digest matches the reference model.
- reset_n asserted during FEED of block 0 -> all outputs at reset values next edge; subsequent L=3 run gives the correct digest.
- msg_start pulse while busy, plus spurious core_done in FILL -> no effect on the sequence or the digest.
